// File: rtl/wb_arbiter_2m_if.sv
// Wishbone bus bundle shared by both masters and the slave side of wb_arbiter_2m.
// The master modport drives a request; the slave modport answers it.
interface wb_arbiter_2m_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  write;
    logic                  strobe;
    logic                  cycle;
    logic                  ack;
    logic                  err;

    modport master (
        output address, writedata, write, strobe, cycle,
        input  readdata, ack, err
    );

    modport slave (
        input  address, writedata, write, strobe, cycle,
        output readdata, ack, err
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter: round-robin grant held for the owner's whole
// cycle, with a stall watchdog that aborts a slave access that never acks.
module wb_arbiter_2m #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_arbiter_2m_if.slave         m0_io,
    wb_arbiter_2m_if.slave         m1_io,
    wb_arbiter_2m_if.master        s_io,
    output logic [1:0]             grant
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;

    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic [1:0]     grant_q, grant_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           owner_cycle;
    logic           timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        wd_d    = '0;
        timeout = 1'b0;

        s_io.address   = '0;
        s_io.writedata = '0;
        s_io.write     = 1'b0;
        s_io.strobe    = 1'b0;
        s_io.cycle     = 1'b0;
        m0_io.ack      = 1'b0;
        m0_io.err      = 1'b0;
        m1_io.ack      = 1'b0;
        m1_io.err      = 1'b0;
        // Read data is broadcast; only ack/err are steered to the owner.
        m0_io.readdata = s_io.readdata;
        m1_io.readdata = s_io.readdata;

        owner_cycle = owner_q ? m1_io.cycle : m0_io.cycle;

        unique case (state_q)
            StIdle: begin
                if (m0_io.cycle || m1_io.cycle) begin
                    owner_d = (m0_io.cycle && m1_io.cycle) ? ~last_q : m1_io.cycle;
                    grant_d = {owner_d, ~owner_d};
                    state_d = StBusy;
                end
            end
            StBusy: begin
                s_io.address   = owner_q ? m1_io.address   : m0_io.address;
                s_io.writedata = owner_q ? m1_io.writedata : m0_io.writedata;
                s_io.write     = owner_q ? m1_io.write     : m0_io.write;
                s_io.strobe    = owner_q ? m1_io.strobe    : m0_io.strobe;
                s_io.cycle     = owner_q ? m1_io.cycle     : m0_io.cycle;

                // A late ack in the final watchdog cycle still completes normally.
                timeout = s_io.strobe && !s_io.ack && (wd_q == WdW'(TIMEOUT - 1));

                m0_io.ack = !owner_q && s_io.ack;
                m1_io.ack =  owner_q && s_io.ack;
                m0_io.err = !owner_q && timeout;
                m1_io.err =  owner_q && timeout;

                if (!owner_cycle) begin
                    last_d  = owner_q;
                    grant_d = 2'b00;
                    state_d = StIdle;
                end else if (timeout) begin
                    state_d = StAbort;
                end else if (s_io.strobe && !s_io.ack) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StAbort: begin
                if (!owner_cycle) begin
                    last_d  = owner_q;
                    grant_d = 2'b00;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: per-master scoreboards of expected responses
// plus timed grant sequences for arbitration, watchdog and reset scenarios.
module tb_wb_arbiter_2m;

    localparam int unsigned Timeout = 64;

    typedef struct {
        logic        err;
        logic [4:0]  addr;
        logic [15:0] data;
        logic        wr;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] grant;
    logic auto_ack = 1'b0;
    logic force_ack = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int strobe_run = 0;
    exp_t exp0_q[$];
    exp_t exp1_q[$];
    logic [1:0] grant_exp[$];

    wb_arbiter_2m_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) m0_bus ();
    wb_arbiter_2m_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) m1_bus ();
    wb_arbiter_2m_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) s_bus ();

    wb_arbiter_2m #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .TIMEOUT(Timeout)) dut (
        .clk   (clk),
        .reset (reset),
        .m0_io (m0_bus),
        .m1_io (m1_bus),
        .s_io  (s_bus),
        .grant (grant)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] slave_rd(input logic [4:0] a);
        return {11'h5A3, a};
    endfunction

    assign s_bus.readdata = slave_rd(s_bus.address);
    assign s_bus.ack      = auto_ack ? s_bus.strobe : force_ack;
    assign s_bus.err      = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb, input logic wr,
                         input logic [4:0] a, input logic [15:0] d);
        if (m == 0) begin
            m0_bus.cycle = cyc; m0_bus.strobe = stb; m0_bus.write = wr;
            m0_bus.address = a; m0_bus.writedata = d;
        end else begin
            m1_bus.cycle = cyc; m1_bus.strobe = stb; m1_bus.write = wr;
            m1_bus.address = a; m1_bus.writedata = d;
        end
    endtask

    task automatic sb_push(input int m, input logic err, input logic [4:0] a,
                           input logic [15:0] d, input logic wr, input int cnt);
        exp_t e;
        e.err = err; e.addr = a; e.data = d; e.wr = wr; e.cnt = cnt;
        if (m == 0) exp0_q.push_back(e);
        else exp1_q.push_back(e);
    endtask

    task automatic sb_pop(input int m, input int run);
        exp_t e;
        logic [1:0] acks, errs, hot;
        acks = {m1_bus.ack, m0_bus.ack};
        errs = {m1_bus.err, m0_bus.err};
        hot  = (m == 0) ? 2'b01 : 2'b10;
        if ((m == 0 && exp0_q.size() == 0) || (m == 1 && exp1_q.size() == 0)) begin
            check_eq("unexpected_resp", {28'd0, errs & hot, acks & hot}, 32'd0);
            return;
        end
        e = (m == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
        check_eq("ack", acks, e.err ? 2'b00 : hot);
        check_eq("err", errs, e.err ? hot : 2'b00);
        check_eq("s_address", s_bus.address, e.addr);
        check_eq("s_writedata", s_bus.writedata, e.data);
        check_eq("s_write", s_bus.write, e.wr);
        check_eq("readdata", (m == 0) ? m0_bus.readdata : m1_bus.readdata, slave_rd(e.addr));
        if (e.cnt != 0) check_eq("strobe_cycles", run, e.cnt);
    endtask

    // Response monitor: counts consecutive un-acked strobe cycles and drains the scoreboards.
    always @(negedge clk) begin
        int run_now;
        run_now = s_bus.strobe ? strobe_run + 1 : 0;
        if (!reset && (m0_bus.ack || m0_bus.err)) sb_pop(0, run_now);
        if (!reset && (m1_bus.ack || m1_bus.err)) sb_pop(1, run_now);
        strobe_run <= (s_bus.strobe && !s_bus.ack) ? run_now : 0;
    end

    task automatic xfer(input int m, input logic [4:0] a, input logic [15:0] d,
                        input logic wr, input int beats);
        for (int b = 0; b < beats; b++) begin
            logic got;
            drive(m, 1'b1, 1'b1, wr, a + 5'(b), d + 16'(b));
            sb_push(m, 1'b0, a + 5'(b), d + 16'(b), wr, 0);
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                got = (m == 0) ? m0_bus.ack : m1_bus.ack;
            end
            check_eq("xfer_ack", got, 1'b1);
            @(posedge clk); #1;
        end
        drive(m, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
    endtask

    task automatic watch_grant();
        while (grant_exp.size() > 0) begin
            @(negedge clk);
            check_eq("grant_seq", grant, grant_exp.pop_front());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_slave_idle(input string tag);
        check_eq({tag, "_s_cycle"}, s_bus.cycle, 1'b0);
        check_eq({tag, "_s_strobe"}, s_bus.strobe, 1'b0);
        check_eq({tag, "_s_write"}, s_bus.write, 1'b0);
        check_eq({tag, "_s_address"}, s_bus.address, 5'd0);
        check_eq({tag, "_s_writedata"}, s_bus.writedata, 16'd0);
        check_eq({tag, "_grant"}, grant, 2'b00);
        check_eq({tag, "_ack_err"}, {m1_bus.err, m1_bus.ack, m0_bus.err, m0_bus.ack}, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic got;
        drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        do_reset();
        @(negedge clk);
        check_slave_idle("reset");
        @(posedge clk); #1;

        // 1: single m0 write, one cycle of arbitration latency
        drive(0, 1'b1, 1'b1, 1'b1, 5'h03, 16'h000A);
        @(negedge clk);
        check_eq("t1_grant_latency", grant, 2'b00);
        check_eq("t1_idle_s_cycle", s_bus.cycle, 1'b0);
        @(posedge clk); #1;
        check_eq("t1_grant", grant, 2'b01);
        check_eq("t1_s_cycle", s_bus.cycle, 1'b1);
        check_eq("t1_s_strobe", s_bus.strobe, 1'b1);
        check_eq("t1_m0_ack_wait", m0_bus.ack, 1'b0);
        force_ack = 1'b1;
        sb_push(0, 1'b0, 5'h03, 16'h000A, 1'b1, 0);
        @(negedge clk);
        check_eq("t1_m1_ack", m1_bus.ack, 1'b0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        @(posedge clk); #1;
        check_eq("t1_release", grant, 2'b00);

        // 2: simultaneous requests after reset, then a repeated tie
        do_reset();
        auto_ack = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            grant_exp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
            fork
                xfer(0, 5'h08, 16'h1111, 1'b1, 1);
                xfer(1, 5'h10, 16'h2222, 1'b0, 1);
                watch_grant();
            join
            @(posedge clk); #1;
        end

        // 3: m1 holds three beats while m0 waits
        grant_exp = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
        fork
            xfer(1, 5'h18, 16'h3000, 1'b1, 3);
            begin
                repeat (2) @(posedge clk);
                #1 xfer(0, 5'h04, 16'h4000, 1'b0, 1);
            end
            watch_grant();
        join
        @(posedge clk); #1;

        // 4: slave never acks -> watchdog abort
        auto_ack = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b1, 5'h1F, 16'hFFFF);
        sb_push(0, 1'b1, 5'h1F, 16'hFFFF, 1'b1, Timeout);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = m0_bus.err;
        end
        check_eq("t4_err_seen", got, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t4_abort_s_cycle", s_bus.cycle, 1'b0);
        check_eq("t4_abort_s_strobe", s_bus.strobe, 1'b0);
        check_eq("t4_abort_err_low", m0_bus.err, 1'b0);
        check_eq("t4_abort_grant", grant, 2'b01);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("t4_grant_held", grant, 2'b01);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        @(posedge clk); #1;
        check_eq("t4_release", grant, 2'b00);

        // 5: ack arrives on the last watchdog cycle
        drive(1, 1'b1, 1'b1, 1'b0, 5'h07, 16'h1234);
        sb_push(1, 1'b0, 5'h07, 16'h1234, 1'b0, Timeout);
        repeat (Timeout) @(posedge clk);
        #1 force_ack = 1'b1;
        @(negedge clk);
        check_eq("t5_no_err", m1_bus.err, 1'b0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        @(posedge clk); #1;
        check_eq("t5_release", grant, 2'b00);

        // 6: reset while m1 is mid-transfer
        drive(1, 1'b1, 1'b1, 1'b1, 5'h0C, 16'hBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t6_busy_strobe", s_bus.strobe, 1'b1);
        check_eq("t6_busy_grant", grant, 2'b10);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_slave_idle("t6_reset");
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 5'h02, 16'h0000);
        @(posedge clk); #1;
        check_eq("t6_first_grant", grant, 2'b01);
        drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        @(posedge clk); #1;
        check_eq("t6_release", grant, 2'b00);

        check_eq("sb0_left", exp0_q.size(), 0);
        check_eq("sb1_left", exp1_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
